feexp_arbiter: RTL and testbench



---
 rtl/feexp_arbiter_if.sv | 31 +++
 rtl/feexp_arbiter.sv | 161 ++++++++++++++++
 tb/tb_feexp_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feexp_arbiter_if.sv
// Requester and feexp-side signal bundle for feexp_arbiter.
// master = arbiter side, slave = requesters plus the feexp unit.
interface feexp_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]     req;
  logic [NREQ*255-1:0] a_in;
  logic [NREQ*255-1:0] b_in;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     rsp_valid;
  logic [254:0]        result;
  logic                rsp_err;
  logic                busy;
  logic                exp_start;
  logic [254:0]        exp_a;
  logic [254:0]        exp_b;
  logic                exp_done;
  logic [254:0]        exp_out;

  modport master (
    input  req, a_in, b_in, exp_done, exp_out,
    output ack, rsp_valid, result, rsp_err,
    output busy, exp_start, exp_a, exp_b
  );

  modport slave (
    output req, a_in, b_in, exp_done, exp_out,
    input  ack, rsp_valid, result, rsp_err,
    input  busy, exp_start, exp_a, exp_b
  );
endinterface

// File: rtl/feexp_arbiter.sv
// Round-robin arbiter sharing one feexp unit among NREQ requesters.
// Optional watchdog abort in BUSY: define FEEXP_ARB_TIMEOUT_EN.
module feexp_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic            clock,
  input  logic            reset_n,
  feexp_arbiter_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   pick;
  logic [SW-1:0]   sum;
  logic            found;
  logic [254:0]    a_q, a_d;
  logic [254:0]    b_q, b_d;
  logic [254:0]    res_q, res_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] rv_q, rv_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            first_q, first_d;
  logic            err_q, err_d;
  logic            done_ok;
  logic            to_hit;

`ifdef FEEXP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign to_hit = (state_q == S_BUSY) &&
                  (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == S_BUSY) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign to_hit = 1'b0;
`endif

  // Search upward from the last winner, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = {1'b0, rr_q} + SW'(i);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      if (!found && bus.req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  // A done seen in the first BUSY cycle may belong to an abandoned op.
  assign done_ok = bus.exp_done && !first_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LAUNCH;
          owner_d = pick;
          rr_d    = pick;
          a_d     = bus.a_in[255*pick +: 255];
          b_d     = bus.b_in[255*pick +: 255];
        end
      end
      S_LAUNCH: state_d = S_BUSY;
      S_BUSY: begin
        if (done_ok) begin
          res_d   = bus.exp_out;
          state_d = S_RESP;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_LAUNCH);
    busy_d  = (state_d != S_IDLE);
    first_d = (state_d == S_BUSY) && (state_q != S_BUSY);
    ack_d   = '0;
    rv_d    = '0;
    if (start_d)
      ack_d = {{(NREQ-1){1'b0}}, 1'b1} << owner_d;
    if (state_d == S_RESP)
      rv_d  = {{(NREQ-1){1'b0}}, 1'b1} << owner_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= IW'(NREQ - 1);
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ack_q   <= '0;
      rv_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rsp_valid = rv_q;
  assign bus.result    = res_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = busy_q;
  assign bus.exp_start = start_q;
  assign bus.exp_a     = a_q;
  assign bus.exp_b     = b_q;

endmodule

// File: tb/tb_feexp_arbiter.sv
// Bench for feexp_arbiter: feexp model, round-robin scoreboard,
// directed steps followed by randomized batches.
module tb_feexp_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;
  localparam logic [256:0] PP = (257'd1 << 255) - 257'd19;
  localparam logic [254:0] PM2 = 255'(PP - 257'd2);
  localparam logic [254:0] INV7 =
    255'(((257'd1 << 256) - 257'd37) / 257'd7);

  typedef struct {
    int idx; int cyc; logic [254:0] a; logic [254:0] b;
  } ack_t;
  typedef struct {
    int idx; int cyc; logic [254:0] r; logic err;
    logic [254:0] ea;
  } rsp_t;
  typedef struct {
    int idx; logic [254:0] a; logic [254:0] b;
    logic [254:0] r; logic err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  ack_t ack_q[$];
  rsp_t rsp_q[$];
  exp_t exp_q[$];
  int   lat_q[$];

  logic [254:0] opa [NREQ];
  logic [254:0] opb [NREQ];
  int   model_last = NREQ - 1;
  bit   hold_mode = 0;
  bit   hang = 0, kick = 0, stale_inj = 0, inj = 0;
  int   fixed_lat = 0;
  int   mcnt = 0;
  logic [254:0] mres = '0;
  logic prev_start = 1'b0;

  feexp_arbiter_if #(.NREQ(NREQ)) bus ();

  feexp_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [254:0] mulm(input logic [254:0] x,
                                        input logic [254:0] y);
    logic [256:0] r;
    r = '0;
    for (int i = 254; i >= 0; i--) begin
      r = r << 1;
      if (r >= PP) r = r - PP;
      if (y[i]) begin
        r = r + {2'b00, x};
        if (r >= PP) r = r - PP;
      end
    end
    return r[254:0];
  endfunction

  function automatic logic [254:0] modexp(input logic [254:0] a,
                                          input logic [254:0] b);
    logic [254:0] aa, r;
    aa = a;
    if ({2'b00, aa} >= PP) aa = 255'({2'b00, aa} - PP);
    r = 255'd1;
    for (int i = 254; i >= 0; i--) begin
      r = mulm(r, r);
      if (b[i]) r = mulm(r, aa);
    end
    return r;
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return t[254:0];
  endfunction

  // feexp unit model: fixed or random latency, optional hang,
  // optional spurious done one cycle after start.
  initial begin
    int l;
    bus.exp_done = 1'b0;
    bus.exp_out  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.exp_done = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          bus.exp_done = 1'b1;
          bus.exp_out  = mres;
        end
      end
      if (inj) begin
        inj = 0;
        bus.exp_done = 1'b1;
        bus.exp_out  = 255'd12345;
      end
      if (kick) begin
        kick = 0;
        bus.exp_done = 1'b1;
        bus.exp_out  = mres;
      end
      if (bus.exp_start === 1'b1) begin
        mres = modexp(bus.exp_a, bus.exp_b);
        l = hang ? TO :
            (fixed_lat > 0 ? fixed_lat : $urandom_range(2, 7));
        lat_q.push_back(l);
        mcnt = hang ? 0 : l;
        inj = stale_inj;
        stale_inj = 0;
      end
    end
  end

  // Protocol monitor and requester-side drop/scramble after ack.
  initial begin
    forever begin
      @(negedge clk);
      chk("ack_onehot", 256'($countones(bus.ack) <= 1), 1);
      chk("rsp_onehot", 256'($countones(bus.rsp_valid) <= 1), 1);
      chk("start_twice", 256'(bus.exp_start & prev_start), 0);
      chk("ack_with_start", 256'(|bus.ack), 256'(bus.exp_start));
      prev_start = bus.exp_start;
      for (int k = 0; k < NREQ; k++) begin
        if (bus.ack[k] === 1'b1) begin
          ack_q.push_back('{k, cyc, bus.exp_a, bus.exp_b});
          if (!hold_mode) begin
            bus.req[k] = 1'b0;
            bus.a_in[255*k +: 255] = rnd255();
            bus.b_in[255*k +: 255] = rnd255();
          end
        end
        if (bus.rsp_valid[k] === 1'b1)
          rsp_q.push_back('{k, cyc, bus.result, bus.rsp_err,
                            bus.exp_a});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic raise(input int k, input logic [254:0] a,
                       input logic [254:0] b);
    opa[k] = a;
    opb[k] = b;
    bus.a_in[255*k +: 255] = a;
    bus.b_in[255*k +: 255] = b;
    bus.req[k] = 1'b1;
  endtask

  // Expected grant order from the round-robin rule.
  task automatic plan(input logic [NREQ-1:0] mask, input bit hold,
                      input int n);
    logic [NREQ-1:0] m;
    int g;
    m = mask;
    for (int j = 0; j < n; j++) begin
      g = -1;
      for (int i = 1; i <= NREQ; i++)
        if (g < 0 && m[(model_last + i) % NREQ])
          g = (model_last + i) % NREQ;
      if (g < 0) break;
      exp_q.push_back('{g, opa[g], opb[g],
                        modexp(opa[g], opb[g]), 1'b0});
      model_last = g;
      if (!hold) m[g] = 1'b0;
    end
  endtask

  task automatic wait_acks(input int n, input int budget);
    for (int t = 0; t < budget && ack_q.size() < n; t++)
      @(negedge clk);
    chk("ack_arrived", 256'(ack_q.size() >= n), 1);
  endtask

  task automatic check_batch(input int n);
    ack_t a;
    rsp_t r;
    exp_t e;
    int   l;
    for (int t = 0; t < n * 60 && rsp_q.size() < n; t++)
      @(negedge clk);
    chk("rsp_count", 256'(rsp_q.size()), 256'(n));
    repeat (2) @(negedge clk);
    chk("ack_count", 256'(ack_q.size()), 256'(n));
    chk("busy_idle", 256'(bus.busy), 0);
    for (int i = 0; i < n; i++) begin
      if (ack_q.size() == 0 || rsp_q.size() == 0 ||
          exp_q.size() == 0 || lat_q.size() == 0) break;
      a = ack_q.pop_front();
      r = rsp_q.pop_front();
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      chk("grant_idx", 256'(a.idx), 256'(e.idx));
      chk("cap_a", 256'(a.a), 256'(e.a));
      chk("cap_b", 256'(a.b), 256'(e.b));
      chk("rsp_idx", 256'(r.idx), 256'(e.idx));
      chk("result", 256'(r.r), 256'(e.r));
      chk("rsp_err", 256'(r.err), 256'(e.err));
      chk("latency", 256'(r.cyc - a.cyc), 256'(l + 1));
      chk("exp_a_held", 256'(r.ea), 256'(a.a));
    end
    ack_q.delete();
    rsp_q.delete();
    exp_q.delete();
    lat_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 256'(bus.busy), 0);
    chk({tag, "_ack"}, 256'(bus.ack), 0);
    chk({tag, "_rsp_valid"}, 256'(bus.rsp_valid), 0);
    chk({tag, "_rsp_err"}, 256'(bus.rsp_err), 0);
    chk({tag, "_exp_start"}, 256'(bus.exp_start), 0);
    chk({tag, "_result"}, 256'(bus.result), 0);
    chk({tag, "_exp_a"}, 256'(bus.exp_a), 0);
    chk({tag, "_exp_b"}, 256'(bus.exp_b), 0);
  endtask

  initial begin
    logic [254:0]    t128, prev;
    logic [NREQ-1:0] mask;
    int              c0;

    rst_n    = 1'b0;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // single request, 7^2
    @(negedge clk);
    c0 = cyc;
    raise(0, 255'd7, 255'd2);
    plan(4'b0001, 0, 1);
    wait_acks(1, 10);
    if (ack_q.size() > 0)
      chk("req_to_ack", 256'(ack_q[0].cyc - c0), 1);
    check_batch(1);
    chk("res_49", 256'(bus.result), 256'd49);

    // two simultaneous requests
    @(negedge clk);
    t128 = '0;
    t128[128] = 1'b1;
    raise(1, t128, 255'd2);
    raise(2, 255'd2, 255'd255);
    plan(4'b0110, 0, 2);
    check_batch(2);
    chk("res_19", 256'(bus.result), 256'd19);

    // reset in BUSY, then stale done in first BUSY cycle
    @(negedge clk);
    fixed_lat = 12;
    raise(0, 255'd7, PM2);
    wait_acks(1, 10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    ack_q.delete();
    rsp_q.delete();
    exp_q.delete();
    lat_q.delete();
    model_last = NREQ - 1;
    repeat (2) @(negedge clk);
    fixed_lat = 0;
    rst_n = 1'b1;
    stale_inj = 1;
    raise(3, 255'd7, 255'd2);
    plan(4'b1000, 0, 1);
    check_batch(1);
    chk("res_after_rst", 256'(bus.result), 256'd49);

    // all requests held: rotation
    @(negedge clk);
    hold_mode = 1;
    for (int k = 0; k < NREQ; k++) raise(k, 255'd2, 255'd254);
    plan(4'b1111, 1, 5);
    wait_acks(5, 200);
    bus.req = '0;
    hold_mode = 0;
    check_batch(5);

    // inverse of 7 with operands scrambled after ack
    @(negedge clk);
    raise(0, 255'd7, PM2);
    plan(4'b0001, 0, 1);
    check_batch(1);
    chk("inv7", 256'(bus.result), 256'(INV7));

    // feexp never answers
    prev = bus.result;
    hang = 1;
    @(negedge clk);
    raise(2, 255'd3, 255'd5);
    plan(4'b0100, 0, 1);
    wait_acks(1, 10);
`ifdef FEEXP_ARB_TIMEOUT_EN
    if (exp_q.size() > 0) begin
      exp_q[0].r   = prev;
      exp_q[0].err = 1'b1;
    end
    check_batch(1);
    chk("to_result_held", 256'(bus.result), 256'(prev));
    hang = 0;
    kick = 1;
    repeat (5) @(negedge clk);
    chk("late_done_rsp", 256'(rsp_q.size()), 0);
    chk("late_done_res", 256'(bus.result), 256'(prev));
    chk("late_done_busy", 256'(bus.busy), 0);
    ack_q.delete();
    lat_q.delete();
`else
    repeat (40) @(negedge clk);
    chk("stuck_busy", 256'(bus.busy), 1);
    chk("stuck_no_rsp", 256'(rsp_q.size()), 0);
    chk("stuck_res", 256'(bus.result), 256'(prev));
    hang = 0;
    if (ack_q.size() > 0) begin
      lat_q.delete();
      lat_q.push_back(cyc + 1 - ack_q[0].cyc);
    end
    kick = 1;
    check_batch(1);
    chk("res_243", 256'(bus.result), 256'd243);
`endif

    // random batches
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int k = 0; k < NREQ; k++)
        if (mask[k]) raise(k, rnd255(), rnd255());
      plan(mask, 0, $countones(mask));
      check_batch($countones(mask));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
